// File: rtl/aclk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aclk_pkg                                                   |
// | Purpose  : Shared definitions for the alarm clock blocks: controller  |
// |            state encoding, the "no key" keypad code, and the LCD      |
// |            character codes used by the display driver.                |
// | Contents : state_t, NOKEY, ZERO..NINE, ERROR, is_digit()              |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package aclk_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [3:0] NOKEY = 4'd10;

  // LCD character codes
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] ONE   = 8'h31;
  localparam logic [7:0] TWO   = 8'h32;
  localparam logic [7:0] THREE = 8'h33;
  localparam logic [7:0] FOUR  = 8'h34;
  localparam logic [7:0] FIVE  = 8'h35;
  localparam logic [7:0] SIX   = 8'h36;
  localparam logic [7:0] SEVEN = 8'h37;
  localparam logic [7:0] EIGHT = 8'h38;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] ERROR = 8'h45;

  // Codes 10..15 all count as "no key pressed".
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aclk_timeout_counter                                       |
// | Purpose  : Counts one_second pulses while enabled, saturating at      |
// |            TIMEOUT_SEC; timeout is high once the limit is reached.    |
// | Ports    : clock, reset_n (sync, active-low), enable, clear,          |
// |            one_second -> timeout                                      |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module aclk_timeout_counter #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  input  logic one_second,
  output logic timeout
);

  localparam int             CW    = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_SEC);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable && one_second && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/aclk_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aclk_controller                                            |
// | Purpose  : Central alarm clock control FSM. Decodes keypad digits and |
// |            the alarm/time buttons, strobes the key shift register and |
// |            the alarm/time loads, selects the LCD source, and abandons |
// |            key entry after TIMEOUT_SEC seconds of inactivity.         |
// | Ports    : clock, reset_n (sync, active-low), one_second, key[3:0],   |
// |            alarm_button, time_button -> show_alarm, show_new_time,    |
// |            shift, load_new_a, load_new_c, reset_count                 |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module aclk_controller
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       show_alarm,
  output logic       show_new_time,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count
);

  state_t state;
  state_t state_next;
  logic   kp;
  logic   timeout;
  logic   count_en;

  assign kp = is_digit(key);

  // The timeout only runs while a digit entry is in progress; every other
  // state (including KEY_STORED) holds it at zero so each digit restarts it.
  assign count_en = (state == KEY_WAITED) || (state == KEY_ENTRY);

  aclk_timeout_counter #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timeout (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (count_en),
    .clear      (!count_en),
    .one_second (one_second),
    .timeout    (timeout)
  );

  always_comb begin
    state_next = SHOW_TIME;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)  state_next = SHOW_ALARM;
        else if (kp)       state_next = KEY_STORED;
        else               state_next = SHOW_TIME;
      end
      KEY_STORED:          state_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!kp)           state_next = KEY_ENTRY;
        else if (timeout)  state_next = SHOW_TIME;
        else               state_next = KEY_WAITED;
      end
      KEY_ENTRY: begin
        // A fresh digit outranks a timeout landing in the same cycle.
        if (alarm_button)      state_next = SET_ALARM_TIME;
        else if (time_button)  state_next = SET_CURRENT_TIME;
        else if (kp)           state_next = KEY_STORED;
        else if (timeout)      state_next = SHOW_TIME;
        else                   state_next = KEY_ENTRY;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
        else               state_next = SHOW_ALARM;
      end
      SET_ALARM_TIME:      state_next = SHOW_TIME;
      SET_CURRENT_TIME:    state_next = SHOW_TIME;
      default:             state_next = SHOW_TIME;  // code 7 recovers
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they always equal the Moore decode of the current state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= SHOW_TIME;
      show_alarm    <= 1'b0;
      show_new_time <= 1'b0;
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      reset_count   <= 1'b0;
    end else begin
      state         <= state_next;
      show_alarm    <= (state_next == SHOW_ALARM);
      show_new_time <= (state_next == KEY_STORED) ||
                       (state_next == KEY_WAITED) ||
                       (state_next == KEY_ENTRY);
      shift         <= (state_next == KEY_STORED);
      load_new_a    <= (state_next == SET_ALARM_TIME);
      load_new_c    <= (state_next == SET_CURRENT_TIME);
      reset_count   <= (state_next == SET_CURRENT_TIME);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aclk_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_aclk_controller                                         |
// | Purpose  : Self-checking bench for aclk_controller: a table of        |
// |            single-cycle vectors followed by hand-written timeout      |
// |            sequences.                                                 |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_aclk_controller;
  import aclk_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_alarm;
  logic       show_new_time;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       reset_count;

  aclk_controller #(.TIMEOUT_SEC(10)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .show_alarm    (show_alarm),
    .show_new_time (show_new_time),
    .shift         (shift),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .reset_count   (reset_count)
  );

  always #5 clock = ~clock;

  // outs order: {show_alarm, show_new_time, shift, load_new_a, load_new_c, reset_count}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_STOR = 6'b011000;
  localparam logic [5:0] O_NEW  = 6'b010000;
  localparam logic [5:0] O_ALM  = 6'b100000;
  localparam logic [5:0] O_LDA  = 6'b000100;
  localparam logic [5:0] O_LDC  = 6'b000011;

  typedef struct {
    logic       rst_n;
    logic [3:0] k;
    logic       al;
    logic       tm;
    logic       os;
    state_t     st;
    logic [5:0] outs;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic [3:0] k, input logic al, input logic tm,
                     input logic os, input state_t st, input logic [5:0] o, input logic [7:0] c);
    vec_t v;
    v.rst_n = r; v.k = k; v.al = al; v.tm = tm; v.os = os;
    v.st = st; v.outs = o; v.cnt = c;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [3:0] k, input logic al,
                       input logic tm, input logic os);
    reset_n = r; key = k; alarm_button = al; time_button = tm; one_second = os;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_all(input string name, input state_t st,
                            input logic [5:0] o, input logic [7:0] c);
    check({name, ".state"}, {5'd0, dut.state}, {5'd0, st});
    check({name, ".outs"},
          {2'b00, show_alarm, show_new_time, shift, load_new_a, load_new_c, reset_count},
          {2'b00, o});
    check({name, ".count"}, {4'd0, dut.u_timeout.count}, c);
  endtask

  initial begin
    drive(1'b0, NOKEY, 1'b0, 1'b0, 1'b0);

    add(0, 10, 0, 0, 0, SHOW_TIME,        O_NONE, 0);  // reset
    add(1, 10, 0, 0, 0, SHOW_TIME,        O_NONE, 0);
    add(1, 12, 0, 0, 0, SHOW_TIME,        O_NONE, 0);  // 12 aliases NOKEY
    add(1,  5, 0, 0, 0, KEY_STORED,       O_STOR, 0);  // key 5 held 4 cycles
    add(1,  5, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(1,  5, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(1,  5, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(1, 10, 0, 0, 0, KEY_ENTRY,        O_NEW,  0);
    add(1, 10, 0, 1, 0, SET_CURRENT_TIME, O_LDC,  0);
    add(1, 10, 0, 0, 0, SHOW_TIME,        O_NONE, 0);
    add(1,  3, 0, 0, 0, KEY_STORED,       O_STOR, 0);
    add(1, 10, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(1, 10, 0, 0, 0, KEY_ENTRY,        O_NEW,  0);
    add(1, 10, 1, 1, 0, SET_ALARM_TIME,   O_LDA,  0);  // alarm beats time
    add(1, 10, 0, 0, 0, SHOW_TIME,        O_NONE, 0);
    add(1, 10, 0, 1, 1, SHOW_TIME,        O_NONE, 0);  // time btn / pulse idle here
    add(1, 10, 1, 0, 0, SHOW_ALARM,       O_ALM,  0);  // alarm held 3 cycles
    add(1, 10, 1, 0, 0, SHOW_ALARM,       O_ALM,  0);
    add(1, 10, 1, 0, 0, SHOW_ALARM,       O_ALM,  0);
    add(1, 10, 0, 0, 0, SHOW_TIME,        O_NONE, 0);
    add(1,  7, 1, 0, 0, SHOW_ALARM,       O_ALM,  0);  // alarm beats key
    add(1,  7, 0, 0, 0, SHOW_TIME,        O_NONE, 0);
    add(1,  7, 0, 0, 0, KEY_STORED,       O_STOR, 0);
    add(1, 10, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(1, 10, 0, 0, 0, KEY_ENTRY,        O_NEW,  0);
    add(0,  4, 0, 0, 0, SHOW_TIME,        O_NONE, 0);  // reset beats key
    add(1,  8, 0, 0, 0, KEY_STORED,       O_STOR, 0);
    add(1,  8, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(0,  8, 0, 0, 0, SHOW_TIME,        O_NONE, 0);  // reset mid-entry
    add(1,  8, 0, 0, 0, KEY_STORED,       O_STOR, 0);
    add(1, 10, 0, 0, 0, KEY_WAITED,       O_NEW,  0);
    add(1, 10, 0, 0, 0, KEY_ENTRY,        O_NEW,  0);

    @(negedge clock);
    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].k, vq[i].al, vq[i].tm, vq[i].os);
      tick();
      expect_all($sformatf("vec%0d", i), vq[i].st, vq[i].outs, vq[i].cnt);
    end

    // Nine pulses in KEY_ENTRY, then a digit: entry continues, count restarts.
    for (int i = 1; i <= 9; i++) begin
      drive(1, NOKEY, 0, 0, 1); tick();
      expect_all($sformatf("cnt_p%0d", i), KEY_ENTRY, O_NEW, 8'(i));
      drive(1, NOKEY, 0, 0, 0); tick();
      expect_all($sformatf("cnt_i%0d", i), KEY_ENTRY, O_NEW, 8'(i));
    end
    drive(1, 4'd2, 0, 0, 0); tick();
    expect_all("digit_after_9", KEY_STORED, O_STOR, 8'd9);
    drive(1, NOKEY, 0, 0, 0); tick();
    expect_all("restart_wait", KEY_WAITED, O_NEW, 8'd0);
    tick();
    expect_all("restart_entry", KEY_ENTRY, O_NEW, 8'd0);

    // Reach the limit, then press a key in the timeout cycle: key wins.
    for (int i = 1; i <= 10; i++) begin
      drive(1, NOKEY, 0, 0, 1); tick();
      expect_all($sformatf("kw_p%0d", i), KEY_ENTRY, O_NEW, 8'(i));
    end
    drive(1, 4'd6, 0, 0, 1); tick();
    expect_all("key_beats_timeout", KEY_STORED, O_STOR, 8'd10);
    drive(1, NOKEY, 0, 0, 0); tick();
    expect_all("kw_wait", KEY_WAITED, O_NEW, 8'd0);
    tick();
    expect_all("kw_entry", KEY_ENTRY, O_NEW, 8'd0);

    // Ten back-to-back pulses, then the timeout returns to SHOW_TIME;
    // an extra pulse at the limit must not move the count past 10.
    for (int i = 1; i <= 10; i++) begin
      drive(1, NOKEY, 0, 0, 1); tick();
      expect_all($sformatf("to_p%0d", i), KEY_ENTRY, O_NEW, 8'(i));
    end
    tick();
    expect_all("timeout_exit", SHOW_TIME, O_NONE, 8'd10);
    drive(1, NOKEY, 0, 0, 0); tick();
    expect_all("timeout_clear", SHOW_TIME, O_NONE, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
